// File: rtl/wl_core_data_demux.sv
// wl_pkg: reqrsp bus types and the NAPOT memory map seen by the core LSU.
// wl_core_data_demux: routes the core LSU reqrsp channel to data memory, the
// CSR file and the HWPE configuration port. A route FIFO records the target
// of every accepted request so that responses return strictly in order.
// Build option: WL_DEMUX_ERR_SLV_EN routes unmapped addresses to an internal
// error slave; without it unmapped addresses fall through to data memory.

package wl_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  size;
    } core_data_req_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic        error;
    } core_data_rsp_chan_t;

    typedef struct packed {
        core_data_req_chan_t q;
        logic                q_valid;
        logic                p_ready;
    } core_data_req_t;

    typedef struct packed {
        core_data_rsp_chan_t p;
        logic                p_valid;
        logic                q_ready;
    } core_data_rsp_t;

    localparam logic [31:0] DMEM_BASE = 32'h0002_0000;
    localparam logic [31:0] DMEM_SIZE = 32'h0000_0200;
    localparam logic [31:0] CSR_BASE  = 32'h0004_0000;
    localparam logic [31:0] CSR_SIZE  = 32'h0000_0004;
    localparam logic [31:0] HWPE_BASE = 32'h0008_0000;
    localparam logic [31:0] HWPE_SIZE = 32'h0000_1000;

endpackage

module wl_core_data_demux #(
    parameter int unsigned NumOutstanding  = 4,
    parameter type         core_data_req_t = wl_pkg::core_data_req_t,
    parameter type         core_data_rsp_t = wl_pkg::core_data_rsp_t
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  core_data_req_t core_req_i,
    output core_data_rsp_t core_rsp_o,
    output core_data_req_t dmem_req_o,
    input  core_data_rsp_t dmem_rsp_i,
    output core_data_req_t csr_req_o,
    input  core_data_rsp_t csr_rsp_i,
    output core_data_req_t hwpe_req_o,
    input  core_data_rsp_t hwpe_rsp_i,
    output logic           busy_o
);

    localparam int unsigned PtrW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
    localparam int unsigned CntW = $clog2(NumOutstanding + 1);

    localparam logic [1:0] TGT_DMEM = 2'd0;
    localparam logic [1:0] TGT_CSR  = 2'd1;
    localparam logic [1:0] TGT_HWPE = 2'd2;
`ifdef WL_DEMUX_ERR_SLV_EN
    localparam logic [1:0] TGT_ERR      = 2'd3;
    localparam logic [1:0] TGT_UNMAPPED = TGT_ERR;
`else
    // DMEM only decodes the low address bits, so stray accesses alias into it.
    localparam logic [1:0] TGT_UNMAPPED = TGT_DMEM;
`endif

    logic [1:0]      sel_idx;
    logic [1:0]      head_idx;
    logic            sel_q_ready;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] fill_cnt;
    logic [1:0]      route_q [NumOutstanding];

    function automatic logic napot_hit(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        return (addr & ~(size - 32'd1)) == base;
    endfunction

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
        if (ptr == PtrW'(NumOutstanding - 1)) begin
            return '0;
        end
        return ptr + PtrW'(1);
    endfunction

    assign fifo_full  = (fill_cnt == CntW'(NumOutstanding));
    assign fifo_empty = (fill_cnt == '0);
    assign head_idx   = route_q[rd_ptr];
    assign busy_o     = ~fifo_empty;

    // Address decode of the request currently presented by the core.
    always_comb begin
        sel_idx = TGT_UNMAPPED;
        if (napot_hit(core_req_i.q.addr, wl_pkg::DMEM_BASE, wl_pkg::DMEM_SIZE)) begin
            sel_idx = TGT_DMEM;
        end else if (napot_hit(core_req_i.q.addr, wl_pkg::CSR_BASE, wl_pkg::CSR_SIZE)) begin
            sel_idx = TGT_CSR;
        end else if (napot_hit(core_req_i.q.addr, wl_pkg::HWPE_BASE, wl_pkg::HWPE_SIZE)) begin
            sel_idx = TGT_HWPE;
        end
    end

    // Broadcast the payload, steer q_valid to the decoded target and p_ready to the FIFO head.
    always_comb begin
        dmem_req_o         = core_req_i;
        csr_req_o          = core_req_i;
        hwpe_req_o         = core_req_i;
        dmem_req_o.q_valid = 1'b0;
        csr_req_o.q_valid  = 1'b0;
        hwpe_req_o.q_valid = 1'b0;
        dmem_req_o.p_ready = 1'b0;
        csr_req_o.p_ready  = 1'b0;
        hwpe_req_o.p_ready = 1'b0;

        case (sel_idx)
            TGT_DMEM: sel_q_ready = dmem_rsp_i.q_ready;
            TGT_CSR:  sel_q_ready = csr_rsp_i.q_ready;
            TGT_HWPE: sel_q_ready = hwpe_rsp_i.q_ready;
            // The internal error slave never stalls.
            default:  sel_q_ready = 1'b1;
        endcase

        if (rst_ni && !fifo_full) begin
            case (sel_idx)
                TGT_DMEM: dmem_req_o.q_valid = core_req_i.q_valid;
                TGT_CSR:  csr_req_o.q_valid  = core_req_i.q_valid;
                TGT_HWPE: hwpe_req_o.q_valid = core_req_i.q_valid;
                default:  ;
            endcase
        end

        if (rst_ni && !fifo_empty) begin
            case (head_idx)
                TGT_DMEM: dmem_req_o.p_ready = core_req_i.p_ready;
                TGT_CSR:  csr_req_o.p_ready  = core_req_i.p_ready;
                TGT_HWPE: hwpe_req_o.p_ready = core_req_i.p_ready;
                default:  ;
            endcase
        end
    end

    // Core-facing handshake: q_ready from the decoded target, response from the FIFO head.
    always_comb begin
        core_rsp_o = '0;
        if (rst_ni) begin
            core_rsp_o.q_ready = sel_q_ready & ~fifo_full;
            if (!fifo_empty) begin
                case (head_idx)
                    TGT_DMEM: begin
                        core_rsp_o.p       = dmem_rsp_i.p;
                        core_rsp_o.p_valid = dmem_rsp_i.p_valid;
                    end
                    TGT_CSR: begin
                        core_rsp_o.p       = csr_rsp_i.p;
                        core_rsp_o.p_valid = csr_rsp_i.p_valid;
                    end
                    TGT_HWPE: begin
                        core_rsp_o.p       = hwpe_rsp_i.p;
                        core_rsp_o.p_valid = hwpe_rsp_i.p_valid;
                    end
`ifdef WL_DEMUX_ERR_SLV_EN
                    TGT_ERR: begin
                        core_rsp_o.p_valid = 1'b1;
                        core_rsp_o.p.error = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // q_ready already includes ~full, so a full FIFO refuses a push even on a pop cycle.
    assign push = core_req_i.q_valid & core_rsp_o.q_ready;
    assign pop  = core_rsp_o.p_valid & core_req_i.p_ready;

    // Route FIFO storage: one target index per accepted request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumOutstanding; i++) begin
                route_q[i] <= '0;
            end
        end else if (push) begin
            route_q[wr_ptr] <= sel_idx;
        end
    end

    // Route FIFO pointers and fill count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fill_cnt <= fill_cnt + CntW'(1);
                2'b01:   fill_cnt <= fill_cnt - CntW'(1);
                default: fill_cnt <= fill_cnt;
            endcase
        end
    end

    // Fill count must stay within the FIFO depth.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (fill_cnt <= CntW'(NumOutstanding))
                else $error("route fifo overflow");
            assert (!(fifo_full && push))
                else $error("push into full route fifo");
        end
    end

endmodule

// File: tb/tb_wl_core_data_demux.sv
// Bench for wl_core_data_demux: decode table, directed multi-cycle sequences
// and a randomized run against an in-order reference model with modelled slaves.
module tb_wl_core_data_demux;
    import wl_pkg::*;

`ifdef WL_DEMUX_ERR_SLV_EN
    localparam int UNM = 3;
`else
    localparam int UNM = 0;
`endif
    localparam int N_OUT = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    core_data_req_t core_req, dmem_req, csr_req, hwpe_req;
    core_data_rsp_t core_rsp, dmem_rsp, csr_rsp, hwpe_rsp;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    wl_core_data_demux #(.NumOutstanding(N_OUT)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .core_req_i (core_req),
        .core_rsp_o (core_rsp),
        .dmem_req_o (dmem_req),
        .dmem_rsp_i (dmem_rsp),
        .csr_req_o  (csr_req),
        .csr_rsp_i  (csr_rsp),
        .hwpe_req_o (hwpe_req),
        .hwpe_rsp_i (hwpe_rsp),
        .busy_o     (busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  rdy;   // {hwpe, csr, dmem} q_ready
        int          tgt;
    } dec_vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        int          tgt;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        int          rdy;
    } slv_t;

    dec_vec_t    vt [14];
    exp_t        exp_q [$];
    slv_t        slv_q [3][$];
    logic [31:0] tag [3];

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0b, want %0b", nm, act, exp);
        else n_pass++;
    endtask

    task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic idle();
        core_req         = '0;
        core_req.p_ready = 1'b1;
        dmem_rsp         = '0;
        csr_rsp          = '0;
        hwpe_rsp         = '0;
        dmem_rsp.q_ready = 1'b1;
        csr_rsp.q_ready  = 1'b1;
        hwpe_rsp.q_ready = 1'b1;
    endtask

    task automatic set_rsp(input int t, input logic qr, input logic pv, input logic [31:0] pd);
        case (t)
            0: begin dmem_rsp.q_ready = qr; dmem_rsp.p_valid = pv; dmem_rsp.p.data = pd; dmem_rsp.p.error = 1'b0; end
            1: begin csr_rsp.q_ready  = qr; csr_rsp.p_valid  = pv; csr_rsp.p.data  = pd; csr_rsp.p.error  = 1'b0; end
            default: begin hwpe_rsp.q_ready = qr; hwpe_rsp.p_valid = pv; hwpe_rsp.p.data = pd; hwpe_rsp.p.error = 1'b0; end
        endcase
    endtask

    function automatic core_data_req_t tgt_req(input int t);
        case (t)
            0:       return dmem_req;
            1:       return csr_req;
            default: return hwpe_req;
        endcase
    endfunction

    function automatic core_data_rsp_t tgt_rsp(input int t);
        case (t)
            0:       return dmem_rsp;
            1:       return csr_rsp;
            default: return hwpe_rsp;
        endcase
    endfunction

    // Memory map as address ranges.
    function automatic int ref_decode(input logic [31:0] a);
        if (a >= 32'h0002_0000 && a < 32'h0002_0200) return 0;
        if (a >= 32'h0004_0000 && a < 32'h0004_0004) return 1;
        if (a >= 32'h0008_0000 && a < 32'h0008_1000) return 2;
        return UNM;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] um [4];
        um[0] = 32'h0002_0200; um[1] = 32'h0004_0004;
        um[2] = 32'h0008_1000; um[3] = 32'h0003_0000;
        case ($urandom_range(0, 5))
            0, 1:    return 32'h0002_0000 + ($urandom_range(0, 127) << 2);
            2:       return 32'h0004_0000 + $urandom_range(0, 3);
            3:       return 32'h0008_0000 + ($urandom_range(0, 1023) << 2);
            4:       return um[$urandom_range(0, 3)];
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        slv_t        s;
        int          pops;
        int          seen;
        logic        exp_qr;
        logic        accepted;
        logic        gen;
        core_data_req_t r;
        core_data_rsp_t rs;

        tag[0] = 32'hD000_0000;
        tag[1] = 32'hC000_0000;
        tag[2] = 32'hA000_0000;

        vt[0]  = '{32'h0002_0010, 3'b111, 0};
        vt[1]  = '{32'h0002_01FC, 3'b111, 0};
        vt[2]  = '{32'h0002_0200, 3'b111, UNM};
        vt[3]  = '{32'h0004_0000, 3'b111, 1};
        vt[4]  = '{32'h0004_0004, 3'b111, UNM};
        vt[5]  = '{32'h0008_0FFC, 3'b111, 2};
        vt[6]  = '{32'h0008_1000, 3'b111, UNM};
        vt[7]  = '{32'h0003_0000, 3'b111, UNM};
        vt[8]  = '{32'h0002_0000, 3'b110, 0};
        vt[9]  = '{32'h0004_0003, 3'b101, 1};
        vt[10] = '{32'h0008_0000, 3'b011, 2};
        vt[11] = '{32'h0001_FFFC, 3'b000, UNM};
        vt[12] = '{32'hFFFF_FFFF, 3'b111, UNM};
        vt[13] = '{32'h0004_0002, 3'b010, 1};

        // Reset state with live-looking inputs.
        rst_n = 1'b0;
        idle();
        core_req.q_valid  = 1'b1;
        core_req.q.addr   = 32'h0002_0010;
        dmem_rsp.p_valid  = 1'b1;
        #12;
        chk1("rst_q_ready", core_rsp.q_ready, 1'b0);
        chk1("rst_p_valid", core_rsp.p_valid, 1'b0);
        chk1("rst_p_error", core_rsp.p.error, 1'b0);
        chkw("rst_p_data", core_rsp.p.data, 32'h0);
        chk1("rst_busy", busy, 1'b0);
        chkw("rst_tgt_valids", {26'h0, dmem_req.q_valid, csr_req.q_valid, hwpe_req.q_valid,
                                dmem_req.p_ready, csr_req.p_ready, hwpe_req.p_ready}, 32'h0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;

        // Decode table: combinational checks, valid dropped before each edge.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            core_req.q.addr  = vt[i].addr;
            core_req.q.write = 1'(i % 2);
            core_req.q.data  = 32'h5A00_0000 + i;
            core_req.q_valid = 1'b1;
            {hwpe_rsp.q_ready, csr_rsp.q_ready, dmem_rsp.q_ready} = vt[i].rdy;
            #1;
            exp_qr = (vt[i].tgt == 3) ? 1'b1 : vt[i].rdy[vt[i].tgt];
            chk1($sformatf("dec%0d_dmem_valid", i), dmem_req.q_valid, vt[i].tgt == 0);
            chk1($sformatf("dec%0d_csr_valid", i),  csr_req.q_valid,  vt[i].tgt == 1);
            chk1($sformatf("dec%0d_hwpe_valid", i), hwpe_req.q_valid, vt[i].tgt == 2);
            chk1($sformatf("dec%0d_q_ready", i), core_rsp.q_ready, exp_qr);
            chkw($sformatf("dec%0d_bcast_addr", i), hwpe_req.q.addr, vt[i].addr);
            core_req.q_valid = 1'b0;
        end
        idle();

        // Single DMEM read with one-cycle latency.
        @(negedge clk);
        core_req.q.addr  = 32'h0002_0010;
        core_req.q_valid = 1'b1;
        #1;
        chk1("rd_dmem_valid", dmem_req.q_valid, 1'b1);
        @(posedge clk); #1;
        core_req.q_valid = 1'b0;
        #1;
        chk1("rd_busy_set", busy, 1'b1);
        chk1("rd_no_early_rsp", core_rsp.p_valid, 1'b0);
        dmem_rsp.p_valid = 1'b1;
        dmem_rsp.p.data  = 32'hCAFE_0001;
        #1;
        chk1("rd_p_valid", core_rsp.p_valid, 1'b1);
        chkw("rd_p_data", core_rsp.p.data, 32'hCAFE_0001);
        chk1("rd_p_error", core_rsp.p.error, 1'b0);
        chk1("rd_dmem_p_ready", dmem_req.p_ready, 1'b1);
        @(posedge clk); #1;
        dmem_rsp.p_valid = 1'b0;
        #1;
        chk1("rd_busy_clr", busy, 1'b0);

        // CSR write then HWPE read; HWPE answers first but must wait.
        @(negedge clk);
        core_req.q.addr  = 32'h0004_0000;
        core_req.q.write = 1'b1;
        core_req.q.data  = 32'h0000_1234;
        core_req.q_valid = 1'b1;
        #1;
        chk1("ord_csr_valid", csr_req.q_valid, 1'b1);
        @(posedge clk); #1;
        core_req.q.addr  = 32'h0008_0FFC;
        core_req.q.write = 1'b0;
        #1;
        chk1("ord_hwpe_valid", hwpe_req.q_valid, 1'b1);
        chk1("ord_hwpe_q_ready", core_rsp.q_ready, 1'b1);
        @(posedge clk); #1;
        core_req.q_valid  = 1'b0;
        hwpe_rsp.p_valid  = 1'b1;
        hwpe_rsp.p.data   = 32'h0000_BEEF;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk1($sformatf("ord_hwpe_held%0d", k), hwpe_req.p_ready, 1'b0);
            chk1($sformatf("ord_core_wait%0d", k), core_rsp.p_valid, 1'b0);
            @(posedge clk); #1;
        end
        csr_rsp.p_valid = 1'b1;
        csr_rsp.p.data  = 32'h0000_C5C5;
        #1;
        chk1("ord_first_valid", core_rsp.p_valid, 1'b1);
        chkw("ord_first_is_csr", core_rsp.p.data, 32'h0000_C5C5);
        chk1("ord_csr_p_ready", csr_req.p_ready, 1'b1);
        chk1("ord_hwpe_still_held", hwpe_req.p_ready, 1'b0);
        @(posedge clk); #1;
        csr_rsp.p_valid = 1'b0;
        #1;
        chk1("ord_second_valid", core_rsp.p_valid, 1'b1);
        chkw("ord_second_is_hwpe", core_rsp.p.data, 32'h0000_BEEF);
        chk1("ord_hwpe_p_ready", hwpe_req.p_ready, 1'b1);
        @(posedge clk); #1;
        hwpe_rsp.p_valid = 1'b0;
        #1;
        chk1("ord_busy_clr", busy, 1'b0);

        // Five DMEM reads with stalled responses: the fifth waits for a pop.
        @(negedge clk);
        core_req.q.addr  = 32'h0002_0040;
        core_req.q_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk1($sformatf("full_acc%0d", i), core_rsp.q_ready, 1'b1);
            @(posedge clk); #1;
            core_req.q.addr = core_req.q.addr + 32'd4;
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            chk1($sformatf("full_block%0d", k), core_rsp.q_ready, 1'b0);
            chk1($sformatf("full_no_valid%0d", k), dmem_req.q_valid, 1'b0);
            @(posedge clk); #1;
        end
        dmem_rsp.p_valid = 1'b1;
        dmem_rsp.p.data  = 32'h0000_0001;
        #1;
        chk1("full_no_bypass", core_rsp.q_ready, 1'b0);
        chk1("full_pop_valid", core_rsp.p_valid, 1'b1);
        @(posedge clk); #1;
        dmem_rsp.p_valid = 1'b0;
        #1;
        chk1("full_fifth_ready", core_rsp.q_ready, 1'b1);
        chk1("full_fifth_valid", dmem_req.q_valid, 1'b1);
        @(posedge clk); #1;
        core_req.q_valid = 1'b0;
        pops = 0;
        for (int c = 0; c < 20; c++) begin
            if (!busy) break;
            dmem_rsp.p_valid = 1'b1;
            #1;
            if (core_rsp.p_valid && core_req.p_ready) pops++;
            @(posedge clk); #1;
        end
        dmem_rsp.p_valid = 1'b0;
        #1;
        chkw("full_drain_pops", pops, 32'd4);
        chk1("full_drain_busy", busy, 1'b0);

        // Unmapped read at 0x0003_0000.
        @(negedge clk);
        core_req.q.addr  = 32'h0003_0000;
        core_req.q_valid = 1'b1;
        #1;
`ifdef WL_DEMUX_ERR_SLV_EN
        chk1("unm_no_dmem", dmem_req.q_valid, 1'b0);
        chk1("unm_q_ready", core_rsp.q_ready, 1'b1);
        @(posedge clk); #1;
        core_req.q_valid = 1'b0;
        #1;
        chk1("unm_p_valid", core_rsp.p_valid, 1'b1);
        chk1("unm_p_error", core_rsp.p.error, 1'b1);
        chkw("unm_p_data", core_rsp.p.data, 32'h0);
`else
        chk1("unm_dmem_valid", dmem_req.q_valid, 1'b1);
        chkw("unm_dmem_addr", dmem_req.q.addr, 32'h0003_0000);
        @(posedge clk); #1;
        core_req.q_valid = 1'b0;
        dmem_rsp.p_valid = 1'b1;
        dmem_rsp.p.data  = 32'h0000_0077;
        #1;
        chk1("unm_p_valid", core_rsp.p_valid, 1'b1);
        chk1("unm_p_error", core_rsp.p.error, 1'b0);
`endif
        @(posedge clk); #1;
        dmem_rsp.p_valid = 1'b0;
        #1;
        chk1("unm_busy_clr", busy, 1'b0);

        // Reset with three requests outstanding, then a fresh read.
        @(negedge clk);
        core_req.p_ready = 1'b0;
        core_req.q.addr  = 32'h0002_0100;
        core_req.q_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        dmem_rsp.p_valid = 1'b1;
        dmem_rsp.p.data  = 32'h0000_0099;
        #1;
        chk1("mrst_busy_before", busy, 1'b1);
        chk1("mrst_p_valid_before", core_rsp.p_valid, 1'b1);
        rst_n            = 1'b0;
        core_req.p_ready = 1'b1;
        #1;
        chk1("mrst_busy", busy, 1'b0);
        chk1("mrst_p_valid", core_rsp.p_valid, 1'b0);
        chk1("mrst_q_ready", core_rsp.q_ready, 1'b0);
        chk1("mrst_dmem_q_valid", dmem_req.q_valid, 1'b0);
        chk1("mrst_dmem_p_ready", dmem_req.p_ready, 1'b0);
        @(negedge clk);
        rst_n            = 1'b1;
        dmem_rsp.p_valid = 1'b0;
        core_req.q.addr  = 32'h0002_0104;
        @(posedge clk); #1;
        core_req.q_valid = 1'b0;
        dmem_rsp.p_valid = 1'b1;
        dmem_rsp.p.data  = 32'h0000_ABCD;
        #1;
        chk1("mrst_new_p_valid", core_rsp.p_valid, 1'b1);
        chkw("mrst_new_p_data", core_rsp.p.data, 32'h0000_ABCD);
        @(posedge clk); #1;
        dmem_rsp.p_valid = 1'b0;
        #1;
        chk1("mrst_new_busy_clr", busy, 1'b0);

        // Randomized traffic against the in-order model.
        @(negedge clk);
        idle();
        @(posedge clk); #1;
        accepted = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            gen = (cyc < 400);
            if (accepted) core_req.q_valid = 1'b0;
            accepted = 1'b0;
            if (!core_req.q_valid && gen && $urandom_range(0, 2) != 0) begin
                core_req.q.addr  = rand_addr();
                core_req.q.write = 1'($urandom_range(0, 1));
                core_req.q.data  = $urandom;
                core_req.q.strb  = 4'hF;
                core_req.q.size  = 2'd2;
                core_req.q_valid = 1'b1;
            end
            core_req.p_ready = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
            for (int t = 0; t < 3; t++) begin
                if (slv_q[t].size() > 0 && slv_q[t][0].rdy <= cyc)
                    set_rsp(t, gen ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b1, slv_q[t][0].data);
                else
                    set_rsp(t, gen ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b0, 32'h0);
            end
            #1;
            chk1("rnd_busy", busy, exp_q.size() != 0);
            if (exp_q.size() == N_OUT) chk1("rnd_full_q_ready", core_rsp.q_ready, 1'b0);
            if (core_rsp.p_valid && core_req.p_ready) begin
                chk1("rnd_rsp_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk1("rnd_rsp_error", core_rsp.p.error, e.tgt == 3);
                    if (!e.write)
                        chkw("rnd_rsp_data", core_rsp.p.data,
                             (e.tgt == 3) ? 32'h0 : (e.addr ^ tag[e.tgt]));
                end
            end
            for (int t = 0; t < 3; t++) begin
                r  = tgt_req(t);
                rs = tgt_rsp(t);
                if (r.q_valid && rs.q_ready) begin
                    s.data = r.q.addr ^ tag[t];
                    s.rdy  = cyc + 1 + int'($urandom_range(0, 3));
                    slv_q[t].push_back(s);
                end
                if (rs.p_valid && r.p_ready) void'(slv_q[t].pop_front());
            end
            if (core_req.q_valid && core_rsp.q_ready) begin
                e.addr  = core_req.q.addr;
                e.write = core_req.q.write;
                e.tgt   = ref_decode(core_req.q.addr);
                seen = 3;
                if (dmem_req.q_valid)      seen = 0;
                else if (csr_req.q_valid)  seen = 1;
                else if (hwpe_req.q_valid) seen = 2;
                chkw("rnd_route", seen, e.tgt);
                exp_q.push_back(e);
                accepted = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (accepted) core_req.q_valid = 1'b0;
        #1;
        chkw("rnd_drained", exp_q.size(), 32'd0);
        chk1("rnd_final_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
